// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if: serial-side inputs, frame configuration and
// parallel-side results of the oversampled UART receiver.
// The master drives the line and configuration; the slave (receiver) drives results.
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      RX_IN;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      Parity_Error;
  logic                      Stop_Error;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, Data_Valid, Parity_Error, Stop_Error
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, Data_Valid, Parity_Error, Stop_Error
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampled UART receiver. Detects the start bit,
// takes a 2-of-3 majority vote around mid-bit, shifts data LSB first, checks
// optional parity and the stop bit, and raises one-cycle result strobes.
// Optional macro UART_RX_SYNC_EN: route RX_IN through a 2-flop synchronizer
// (reset to 1) before any logic; all timing then shifts by two cycles.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input logic                   CLK,
  input logic                   RST,
  uart_rx_deserializer_if.slave bus
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_reg, state_next;
  logic [5:0]              edge_cnt_reg, edge_cnt_next;
  logic [BIT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [5:0]              prescale_reg, prescale_next;
  logic                    par_en_reg, par_en_next;
  logic                    par_typ_reg, par_typ_next;
  logic [2:0]              samp_reg, samp_next;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic                    par_fail_reg, par_fail_next;
  logic                    stop_fail_reg, stop_fail_next;
  logic [DATA_WIDTH-1:0]   p_data_reg, p_data_next;
  logic                    data_valid_reg, data_valid_next;
  logic                    parity_error_reg, parity_error_next;
  logic                    stop_error_reg, stop_error_next;

  logic                      rx;
  logic [PRESCALE_WIDTH-1:0] prescale_in;
  logic [31:0]               prescale_wide;
  logic [5:0]                prescale_norm;
  logic [5:0]                half_p;
  logic [5:0]                tick_res;
  logic [5:0]                tick_last;
  logic                      maj;

`ifdef UART_RX_SYNC_EN
  logic sync1_reg, sync2_reg;

  // Two-stage synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= bus.RX_IN;
      sync2_reg <= sync1_reg;
    end
  end

  assign rx = sync2_reg;
`else
  assign rx = bus.RX_IN;
`endif

  assign prescale_in   = bus.Prescale;
  assign prescale_wide = 32'(prescale_in);

  // Map any requested ratio onto the supported even range 8..32.
  always_comb begin
    prescale_norm = 6'd8;
    if (prescale_wide < 32'd8)
      prescale_norm = 6'd8;
    else if (prescale_wide > 32'd32)
      prescale_norm = 6'd32;
    else
      prescale_norm = {prescale_wide[5:1], 1'b0};
  end

  assign half_p    = {1'b0, prescale_reg[5:1]};
  assign tick_res  = half_p + 6'd1;
  assign tick_last = prescale_reg - 6'd1;
  assign maj       = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & samp_reg[2]) |
                     (samp_reg[1] & samp_reg[2]);

  // Capture the line at the three ticks centred on mid-bit (P/2-2, P/2-1, P/2).
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sample
      assign samp_next[gi] = (edge_cnt_reg == (half_p - 6'd2 + 6'(gi))) ? rx : samp_reg[gi];
    end
  endgenerate

  // State, counters, frame data and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg        <= IDLE;
      edge_cnt_reg     <= '0;
      bit_cnt_reg      <= '0;
      prescale_reg     <= 6'd8;
      par_en_reg       <= 1'b0;
      par_typ_reg      <= 1'b0;
      samp_reg         <= 3'b111;
      shift_reg        <= '0;
      par_fail_reg     <= 1'b0;
      stop_fail_reg    <= 1'b0;
      p_data_reg       <= '0;
      data_valid_reg   <= 1'b0;
      parity_error_reg <= 1'b0;
      stop_error_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      edge_cnt_reg     <= edge_cnt_next;
      bit_cnt_reg      <= bit_cnt_next;
      prescale_reg     <= prescale_next;
      par_en_reg       <= par_en_next;
      par_typ_reg      <= par_typ_next;
      samp_reg         <= samp_next;
      shift_reg        <= shift_next;
      par_fail_reg     <= par_fail_next;
      stop_fail_reg    <= stop_fail_next;
      p_data_reg       <= p_data_next;
      data_valid_reg   <= data_valid_next;
      parity_error_reg <= parity_error_next;
      stop_error_reg   <= stop_error_next;
    end
  end

  // Next-state logic: bit decisions at tick P/2+1, bit transitions at tick P-1.
  always_comb begin
    state_next        = state_reg;
    edge_cnt_next     = edge_cnt_reg;
    bit_cnt_next      = bit_cnt_reg;
    prescale_next     = prescale_reg;
    par_en_next       = par_en_reg;
    par_typ_next      = par_typ_reg;
    shift_next        = shift_reg;
    par_fail_next     = par_fail_reg;
    stop_fail_next    = stop_fail_reg;
    p_data_next       = p_data_reg;
    data_valid_next   = 1'b0;
    parity_error_next = 1'b0;
    stop_error_next   = 1'b0;

    if (state_reg == IDLE) begin
      edge_cnt_next = '0;
      if (!rx) begin
        // This edge is tick 0 of the start bit; the next edge is tick 1.
        state_next     = START;
        edge_cnt_next  = 6'd1;
        bit_cnt_next   = '0;
        prescale_next  = prescale_norm;
        par_en_next    = bus.PAR_EN;
        par_typ_next   = bus.PAR_TYP;
        par_fail_next  = 1'b0;
        stop_fail_next = 1'b0;
      end
    end else begin
      edge_cnt_next = (edge_cnt_reg == tick_last) ? 6'd0 : edge_cnt_reg + 6'd1;

      if (edge_cnt_reg == tick_res) begin
        case (state_reg)
          START: begin
            if (maj) begin
              state_next    = IDLE;
              edge_cnt_next = '0;
            end
          end
          DATA:    shift_next = {maj, shift_reg[DATA_WIDTH-1:1]};
          PARITY:  if (maj != ((^shift_reg) ^ par_typ_reg)) par_fail_next = 1'b1;
          STOP:    if (!maj) stop_fail_next = 1'b1;
          default: ;
        endcase
      end

      if (edge_cnt_reg == tick_last) begin
        case (state_reg)
          START: begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
          DATA: begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1))
              state_next = par_en_reg ? PARITY : STOP;
          end
          PARITY:  state_next = STOP;
          STOP: begin
            state_next = IDLE;
            if (!par_fail_reg && !stop_fail_reg) begin
              p_data_next     = shift_reg;
              data_valid_next = 1'b1;
            end else begin
              parity_error_next = par_fail_reg;
              stop_error_next   = stop_fail_reg;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.P_DATA       = p_data_reg;
  assign bus.Data_Valid   = data_valid_reg;
  assign bus.Parity_Error = parity_error_reg;
  assign bus.Stop_Error   = stop_error_reg;

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Oversampled UART receiver that turns the serial line into parallel bytes for the system's RX control path. Detects start bits, majority-votes each bit, checks optional parity and the stop bit, and emits a one-cycle `Data_Valid` strobe with `P_DATA`. It sits upstream of the RX command controller, which consumes `P_DATA` and `Data_Valid` after clock-domain synchronization.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `PRESCALE_WIDTH`, default 6: width of the `Prescale` input.

- `CLK`  in  1: oversampling clock.
- `RST`  in  1: synchronous reset, active-high.
- `RX_IN`  in  1: serial line, idle high.
- `Prescale`  in  PRESCALE_WIDTH: oversampling ratio in CLK cycles per bit.
- `PAR_EN`  in  1: 1 = a parity bit follows the data bits.
- `PAR_TYP`  in  1: 0 = even parity, 1 = odd parity.
- `P_DATA`  out  DATA_WIDTH: last good byte.
- `Data_Valid`  out  1: one-cycle strobe, good frame received.
- `Parity_Error`  out  1: one-cycle strobe, parity mismatch.
- `Stop_Error`  out  1: one-cycle strobe, stop bit sampled 0.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Reset (RST=1 at a CLK edge) forces IDLE, clears the counters, sets `P_DATA`=0, and sets all strobes to 0. Reset mid-frame aborts the frame with no strobe.
- IDLE: a CLK edge that samples `RX_IN`=0 becomes tick 0 of the start bit; the FSM enters START.
  - `Prescale`, `PAR_EN` and `PAR_TYP` are latched at that same edge. Changes to them mid-frame are ignored.
- Latched `Prescale` rules:
  - Supported values are even values 8..32.
  - Values below 8 clamp to 8.
  - Values above 32 and odd values are treated as the next lower supported even value.
- Edge counter:
  - Counts 0..P-1 within each bit, where P is the latched prescale.
  - It wraps to 0 and advances the bit counter at P-1.
- Sampling:
  - `RX_IN` is sampled at ticks P/2-2, P/2-1 and P/2.
  - The bit value is the 2-of-3 majority, resolved at tick P/2+1.
- START: if the majority is 1 (glitch), return to IDLE at tick P/2+1 with no strobe. Otherwise continue.
- DATA: shifts DATA_WIDTH bits, LSB first.
- PARITY (only when latched `PAR_EN`=1):
  - Expected bit = XOR of the data bits, inverted when `PAR_TYP`=1.
  - A mismatch sets an internal parity-fail flag.
- STOP: a majority value of 0 sets an internal stop-fail flag.
- Frame end (tick P-1 of the stop bit):
  - No fail flags: load `P_DATA` and pulse `Data_Valid`.
  - Otherwise pulse `Parity_Error` and/or `Stop_Error` (both may fire together). `P_DATA` is unchanged and `Data_Valid` is not asserted.
- Back-to-back frames: in the cycle after the stop bit's last tick the FSM is in IDLE and can accept a new start edge immediately. There is no required idle gap.

## Timing
- N = 1 + DATA_WIDTH + PAR_EN + 1 bits per frame.
- Strobes and the `P_DATA` update are registered. They are visible in cycle N*P, counting the start-detect edge as cycle 0.
  - Example: DATA_WIDTH=8, P=8, no parity gives cycle 80.
- Each strobe is high for exactly one CLK cycle.
- `P_DATA` is stable from its update until the next good frame.
- The earliest next start edge is cycle N*P.
- The block has no backpressure. The consumer must take `P_DATA` within N*P cycles of `Data_Valid`.

## Configuration
- `UART_RX_SYNC_EN` defined:
  - `RX_IN` passes through a 2-flop synchronizer (reset to 1) before all logic.
  - All timing above shifts by +2 cycles relative to the raw `RX_IN` edge.
- Not defined: `RX_IN` is used directly and the input must be synchronous to `CLK`.

## Test plan
All cycle numbers below assume the macro is undefined; with `UART_RX_SYNC_EN` defined, add 2.
- 0xA5, P=8, `PAR_EN`=0, stop=1 -> `Data_Valid` pulse at cycle 80, `P_DATA`=0xA5, no error strobes.
- 0x3C, P=16, `PAR_EN`=1, `PAR_TYP`=0, parity bit 0 -> `Data_Valid` at cycle 176, `P_DATA`=0x3C.
- 0x3C, P=8, even parity, parity bit 1 -> `Parity_Error` pulse at cycle 88, no `Data_Valid`, `P_DATA` keeps its prior value.
- 0x81, P=8, no parity, stop bit 0 -> `Stop_Error` pulse at cycle 80. Repeat with wrong parity and stop 0 -> both strobes in the same cycle.
- Glitch: `RX_IN` low for 2 cycles, P=8 -> FSM returns to IDLE at tick 5, no strobes. A following valid 0x55 frame is received correctly.
- RST asserted at cycle 40 of a frame, then a clean 0x0F frame -> no strobe for the aborted frame, 0x0F received. Two back-to-back frames 0x12, 0x34 with zero gap -> two `Data_Valid` strobes 80 cycles apart.
